charge_port_scheduler: RTL and testbench
========================================

CHARGE_PORT_SCHEDULER -- requirements
Module: charge_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_DIV, default 1000, clk cycles per 1 s charge tick.
REQ-002 SHALL have parameter MAX_TIME, default 40, maximum accepted request time in seconds.
REQ-003 SHALL have port clk  input  1  system clock (1 kHz nominal); single clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  4  level request per charging port i.
REQ-006 SHALL have port req_time  input  24  purchased seconds per port; port i at bits [6i+5:6i].
REQ-007 SHALL have port cancel  input  4  level abort per port; acted on at its rising edge.
REQ-008 SHALL have port grant  output  4  one-hot power enable to the granted port; 0 = none.
REQ-009 SHALL have port active_port  output  2  index of the granted port; 0 when none is granted.
REQ-010 SHALL have port remaining_time  output  6  seconds left for the granted port; 0 when idle.
REQ-011 SHALL have port pending  output  4  port i has a latched request that is not yet served.
REQ-012 SHALL have port busy  output  1  high in GRANT and CHARGE states.
REQ-013 SHALL have port done  output  4  one-cycle pulse on port i when its time expires normally.

Function
REQ-014 SHALL register req and cancel each cycle and detect rising edges (prev=0, now=1).
REQ-015 SHALL, on a req[i] rising edge with port i neither pending nor granted, latch min(req_time[i], MAX_TIME) into slot i and set pending[i]; a latched value of 0 SHALL be discarded.
REQ-016 SHALL ignore req edges for a port already pending or granted; its slot is not overwritten.
REQ-017 SHALL use FSM states IDLE, GRANT, CHARGE, RELEASE.
REQ-018 IDLE: if any pending bit is set, SHALL select the first pending port searching round-robin from last_port+1 (mod 4), then go to GRANT; otherwise stay in IDLE.
REQ-019 GRANT (1 cycle): SHALL assert grant/active_port/busy, load remaining_time from the slot, clear the pending bit, clear the tick counter, then go to CHARGE.
REQ-020 CHARGE: the tick counter SHALL count 0..NUM_DIV-1 and tick at NUM_DIV-1; each tick SHALL decrement remaining_time.
REQ-021 A tick with remaining_time==1 SHALL set remaining_time to 0, pulse done[active_port] in the same cycle, and go to RELEASE.
REQ-022 RELEASE (1 cycle): SHALL drive grant=0, busy=0, remaining_time=0, set last_port=active_port, then go to IDLE; this gives break-before-make with at least 2 grant-free cycles between grants.
REQ-023 A cancel edge on the granted port in GRANT or CHARGE SHALL go to RELEASE next cycle with no done pulse; cancel SHALL take priority over a simultaneous expiry tick.
REQ-024 A cancel edge on a pending port SHALL clear its pending bit; a cancel edge on an idle port SHALL be ignored.
REQ-025 A req edge and a cancel edge on the same port in the same cycle SHALL leave the port not pending.
REQ-026 Requests latched during CHARGE SHALL wait; the grant SHALL never be preempted except by cancel or reset.
REQ-027 grant SHALL be one-hot or zero at all times; done SHALL be asserted at most one bit at a time.

Reset
REQ-028 With rst_n=0 at a clk edge: state=IDLE; grant, active_port, remaining_time, pending, busy, done and the tick counter SHALL be 0; last_port=3 so port 0 wins first; req/cancel history SHALL be 0.
REQ-029 Reset mid-charge SHALL abort immediately with no done pulse; req held high through reset SHALL count as a rising edge in the first cycle after reset.

Verification (NUM_DIV=4)
REQ-030 Port 2 req with time 3 -> GRANT next cycle; grant=0100; remaining_time 3,2,1 every 4 cycles; done[2] pulse when it reaches 0; grant=0 for 2 or more cycles.
REQ-031 Ports 0, 1 and 3 request in the same cycle -> served in order 0, 1, 3; a later request from port 0 is served after port 3.
REQ-032 Port 1 charging with remaining_time 5, cancel[1] edge -> RELEASE next cycle, done=0, remaining_time=0, next pending port is granted.
REQ-033 req_time=0 -> no pending bit set; req_time=63 -> remaining_time loads 40.
REQ-034 Port 0 charging, rst_n low for 1 cycle -> all outputs 0 next cycle; no done pulse.
REQ-035 Cancel coinciding with the final tick -> no done pulse; port released.

Source files
------------

// File: rtl/charge_port_scheduler.sv
// Time-sliced scheduler for four charging ports sharing one power stage.
// Requests are latched per port and served round-robin, one port at a time.
//
// state   | meaning
// IDLE    | no port powered; picks the next pending port round-robin
// GRANT   | one-cycle power-on of the selected port; time already loaded
// CHARGE  | port powered; remaining_time counts down once per tick
// RELEASE | one-cycle power-off gap before the next grant
module charge_port_scheduler #(
  parameter int NUM_DIV  = 1000,
  parameter int MAX_TIME = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [23:0] req_time,
  input  logic [3:0]  cancel,
  output logic [3:0]  grant,
  output logic [1:0]  active_port,
  output logic [5:0]  remaining_time,
  output logic [3:0]  pending,
  output logic        busy,
  output logic [3:0]  done
);

  localparam int              CW   = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;
  localparam logic [CW-1:0]   TC   = CW'(NUM_DIV - 1);
  localparam logic [5:0]      MAXT = 6'(MAX_TIME);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_CHARGE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [3:0]      r_req_prev;
  logic [3:0]      r_cancel_prev;
  logic [3:0]      r_pending;
  logic [5:0]      r_slot [4];
  logic [1:0]      r_active;
  logic [1:0]      r_last;
  logic [5:0]      r_remaining;
  logic [CW-1:0]   r_tick_cnt;
  logic [3:0]      r_done;

  logic [3:0]      w_req_rise;
  logic [3:0]      w_cancel_rise;
  logic [3:0]      w_granted_mask;
  logic            w_cancel_active;
  logic            w_tick;
  logic            w_expire;
  logic [3:0]      w_sel_mask;
  logic            w_sel_valid;
  logic [1:0]      w_sel;
  logic [5:0]      w_clip [4];
  logic [3:0]      w_accept;
  logic [3:0]      w_pending_nxt;

  assign w_req_rise    = req & ~r_req_prev;
  assign w_cancel_rise = cancel & ~r_cancel_prev;

  assign w_granted_mask  = ((r_state == S_GRANT) || (r_state == S_CHARGE)) ?
                           (4'b0001 << r_active) : 4'b0000;
  assign w_cancel_active = |(w_cancel_rise & w_granted_mask);
  assign w_tick          = (r_state == S_CHARGE) && (r_tick_cnt == TC);
  assign w_expire        = w_tick && (r_remaining == 6'd1);

  // A port cancelled in the same cycle it would be picked must not be granted.
  assign w_sel_mask = r_pending & ~w_cancel_rise;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_sel_valid && w_sel_mask[2'(r_last + 2'(k))]) begin
        w_sel_valid = 1'b1;
        w_sel       = 2'(r_last + 2'(k));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_clip[i]   = (req_time[6*i +: 6] > MAXT) ? MAXT : req_time[6*i +: 6];
      w_accept[i] = w_req_rise[i] & ~r_pending[i] & ~w_granted_mask[i] &
                    ~w_cancel_rise[i] & (w_clip[i] != 6'd0);
    end
  end

  always_comb begin
    w_pending_nxt = (r_pending & ~w_cancel_rise) | w_accept;
    if ((r_state == S_IDLE) && w_sel_valid) begin
      w_pending_nxt[w_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cancel is checked before expiry so an aborted session never reports done.
  always_comb begin
    w_state_nxt = r_state;
    grant       = 4'b0000;
    busy        = 1'b0;
    active_port = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        grant       = w_granted_mask;
        busy        = 1'b1;
        active_port = r_active;
        w_state_nxt = w_cancel_active ? S_RELEASE : S_CHARGE;
      end
      S_CHARGE: begin
        grant       = w_granted_mask;
        busy        = 1'b1;
        active_port = r_active;
        if (w_cancel_active || w_expire) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_prev    <= 4'b0000;
      r_cancel_prev <= 4'b0000;
      r_pending     <= 4'b0000;
      for (int i = 0; i < 4; i++) r_slot[i] <= 6'd0;
      r_active      <= 2'd0;
      r_last        <= 2'd3;
      r_remaining   <= 6'd0;
      r_tick_cnt    <= '0;
      r_done        <= 4'b0000;
    end else begin
      r_req_prev    <= req;
      r_cancel_prev <= cancel;
      r_pending     <= w_pending_nxt;
      r_done        <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (w_accept[i]) r_slot[i] <= w_clip[i];
      end
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_active    <= w_sel;
            r_remaining <= r_slot[w_sel];
            r_tick_cnt  <= '0;
          end
        end
        S_GRANT: begin
          if (w_cancel_active) r_remaining <= 6'd0;
        end
        S_CHARGE: begin
          if (w_cancel_active) begin
            r_remaining <= 6'd0;
            r_tick_cnt  <= '0;
          end else if (w_tick) begin
            r_tick_cnt  <= '0;
            r_remaining <= r_remaining - 6'd1;
            if (w_expire) r_done <= 4'b0001 << r_active;
          end else begin
            r_tick_cnt <= r_tick_cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          r_last      <= r_active;
          r_remaining <= 6'd0;
          r_tick_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign remaining_time = r_remaining;
  assign pending        = r_pending;
  assign done           = r_done;

endmodule

// File: tb/tb_charge_port_scheduler.sv
// Directed bench for charge_port_scheduler with NUM_DIV=4: a vector table for
// the basic charge/latch/cancel cases plus sequences for multi-cycle corners.
module tb_charge_port_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] req_time;
  logic [3:0]  cancel;
  logic [3:0]  grant;
  logic [1:0]  active_port;
  logic [5:0]  remaining_time;
  logic [3:0]  pending;
  logic        busy;
  logic [3:0]  done;

  int checks = 0;
  int errors = 0;

  charge_port_scheduler #(.NUM_DIV(4), .MAX_TIME(40)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_time       (req_time),
    .cancel         (cancel),
    .grant          (grant),
    .active_port    (active_port),
    .remaining_time (remaining_time),
    .pending        (pending),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        rst;
    logic [3:0]  rq;
    logic [23:0] rt;
    logic [3:0]  cn;
    logic [3:0]  g;
    logic [1:0]  ap;
    logic [5:0]  rem;
    logic [3:0]  pnd;
    logic        bz;
    logic [3:0]  dn;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] mk(input logic [5:0] t0, input logic [5:0] t1,
                                     input logic [5:0] t2, input logic [5:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot_grant", {31'd0, $onehot0(grant)}, 32'd1);
    chk("onehot_done", {31'd0, $onehot0(done)}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string nm, output int gap);
    gap = 0;
    while (grant == 4'b0000 && gap < 100) begin
      step();
      gap++;
    end
    chk({nm, "_grant"}, {28'd0, grant}, 32'(4'b0001 << exp));
    chk({nm, "_port"}, {30'd0, active_port}, {30'd0, exp});
  endtask

  task automatic wait_done(input logic [3:0] exp, input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (done == 4'b0000 && n < 100);
    chk({nm, "_done"}, {28'd0, done}, {28'd0, exp});
    chk({nm, "_rel"}, {22'd0, grant, remaining_time}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_time = 24'd0;
    cancel   = 4'b0000;

    //             n rst  req     req_time         cancel   grant  ap  rem pend   bz  done
    tbl.push_back('{1, 0, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0100, mk(0, 0, 3, 0),  4'b0000, 4'b0000, 0, 0, 4'b0100, 0, 4'b0000});
    tbl.push_back('{5, 1, 4'b0100, mk(0, 0, 3, 0),  4'b0000, 4'b0100, 2, 3, 4'b0000, 1, 4'b0000});
    tbl.push_back('{4, 1, 4'b0100, mk(0, 0, 3, 0),  4'b0000, 4'b0100, 2, 2, 4'b0000, 1, 4'b0000});
    tbl.push_back('{4, 1, 4'b0100, mk(0, 0, 3, 0),  4'b0000, 4'b0100, 2, 1, 4'b0000, 1, 4'b0000});
    tbl.push_back('{1, 1, 4'b0100, mk(0, 0, 3, 0),  4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0100});
    tbl.push_back('{2, 1, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{2, 1, 4'b0001, mk(0, 0, 0, 0),  4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0001, mk(63, 0, 0, 0), 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0001, mk(63, 0, 0, 0), 4'b0000, 4'b0001, 0, 40, 4'b0000, 1, 4'b0000});
    tbl.push_back('{1, 1, 4'b0001, mk(63, 0, 0, 0), 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{2, 1, 4'b0001, mk(63, 0, 0, 0), 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0010, mk(0, 5, 0, 0),  4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b1000, mk(0, 0, 0, 4),  4'b0000, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000});
    tbl.push_back('{1, 1, 4'b1000, mk(0, 0, 0, 4),  4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    tbl.push_back('{2, 1, 4'b0000, 24'd0,           4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});

    foreach (tbl[r]) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        rst_n    = tbl[r].rst;
        req      = tbl[r].rq;
        req_time = tbl[r].rt;
        cancel   = tbl[r].cn;
        step();
        chk($sformatf("vec%0d_c%0d", r, c),
            {11'd0, grant, active_port, remaining_time, pending, busy, done},
            {11'd0, tbl[r].g, tbl[r].ap, tbl[r].rem, tbl[r].pnd, tbl[r].bz, tbl[r].dn});
      end
    end

    // Simultaneous requests from 0, 1, 3; port 0 re-requests during port 1.
    req = 4'b0000; cancel = 4'b0000; req_time = 24'd0;
    do_reset();
    req      = 4'b1011;
    req_time = mk(1, 1, 1, 1);
    wait_grant(2'd0, "rr_first", gap);
    wait_done(4'b0001, "rr_first");
    req[0] = 1'b0;
    wait_grant(2'd1, "rr_second", gap);
    chk("rr_second_gap", {31'd0, gap >= 2}, 32'd1);
    req[0] = 1'b1;
    wait_done(4'b0010, "rr_second");
    wait_grant(2'd3, "rr_third", gap);
    chk("rr_third_gap", {31'd0, gap >= 2}, 32'd1);
    wait_done(4'b1000, "rr_third");
    wait_grant(2'd0, "rr_fourth", gap);
    chk("rr_fourth_gap", {31'd0, gap >= 2}, 32'd1);
    wait_done(4'b0001, "rr_fourth");
    req = 4'b0000;

    // Cancel of the charging port releases it and hands over to the next one.
    do_reset();
    req      = 4'b0110;
    req_time = mk(0, 5, 2, 0);
    wait_grant(2'd1, "cxl_first", gap);
    step();
    chk("cxl_rem5", {26'd0, remaining_time}, 32'd5);
    cancel = 4'b0010;
    step();
    chk("cxl_release", {17'd0, grant, remaining_time, done, busy}, 32'd0);
    cancel = 4'b0000;
    wait_grant(2'd2, "cxl_next", gap);
    chk("cxl_next_rem", {26'd0, remaining_time}, 32'd2);
    cancel = 4'b0100;
    step();
    chk("cxl_next_release", {17'd0, grant, remaining_time, done, busy}, 32'd0);
    cancel = 4'b0000;
    req    = 4'b0000;

    // Cancel arriving on the very tick that would expire the session.
    do_reset();
    req      = 4'b0001;
    req_time = mk(1, 0, 0, 0);
    wait_grant(2'd0, "last_tick", gap);
    repeat (4) step();
    chk("last_tick_rem1", {26'd0, remaining_time}, 32'd1);
    cancel = 4'b0001;
    step();
    chk("last_tick_release", {22'd0, grant, remaining_time}, 32'd0);
    chk("last_tick_nodone", {28'd0, done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("last_tick_nodone_after", {28'd0, done}, 32'd0);
    end
    cancel = 4'b0000;
    req    = 4'b0000;
    step();

    // Reset mid-charge; req held high through reset re-latches afterwards.
    req      = 4'b0001;
    req_time = mk(2, 0, 0, 0);
    wait_grant(2'd0, "rst_mid", gap);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_outputs",
        {11'd0, grant, active_port, remaining_time, pending, busy, done}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_held_req_pending", {28'd0, pending}, 32'b0001);
    chk("rst_after_nodone", {24'd0, grant, done}, 32'd0);
    req = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
